// File: rtl/regfile_term_writer.sv
// regfile_term_writer: paints "Rn" labels and a hex dump of the register
// file into a character terminal, then repaints only changed/forced rows.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   regs           flattened register values, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   force_refresh  one-cycle pulse, marks every register dirty
//   term_h/term_v  character column/row of the current write
//   term_char      character code (space=0, A..Z=1..26, 0..9=27..36)
//   term_w_en      write request, held until term_w_ready
//   term_w_ready   terminal accepts the presented write
//   init_done      sticky, set once labels and the first full dump are done

module regfile_term_writer #(
  parameter int NUM_REGS   = 7,
  parameter int DATA_WIDTH = 16,
  parameter int ORIGIN_H   = 0,
  parameter int ORIGIN_V   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  input  logic                           force_refresh,
  output logic [7:0]                     term_h,
  output logic [7:0]                     term_v,
  output logic [5:0]                     term_char,
  output logic                           term_w_en,
  input  logic                           term_w_ready,
  output logic                           init_done
);

  localparam int NDIG = (DATA_WIDTH + 3) / 4;
  localparam int PW   = NDIG * 4;
  localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [7:0]    OH       = 8'(ORIGIN_H);
  localparam logic [7:0]    OV       = 8'(ORIGIN_V);
  localparam logic [4:0]    LBL_LAST = 5'(2 * NUM_REGS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REGS - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_LABEL,
    S_SCAN,
    S_WRITE
  } state_t;

  state_t                state;
  logic [4:0]            lbl_cnt;
  logic [IW-1:0]         idx;
  logic [KW-1:0]         k;
  logic [NUM_REGS-1:0]   dirty;
  logic [DATA_WIDTH-1:0] shadow   [NUM_REGS];
  logic [DATA_WIDTH-1:0] reg_vals [NUM_REGS];

  logic [DATA_WIDTH-1:0] cur;
  logic                  changed;
  logic                  xfer;
  logic [IW-1:0]         idx_nxt;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
    assign reg_vals[g] = regs[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cur     = reg_vals[idx];
  assign changed = dirty[idx] | (cur != shadow[idx]);
  assign xfer    = term_w_en & term_w_ready;
  assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Label write n: even n is 'R', odd n is the register digit.
  function automatic logic [21:0] label_word(
    input logic [4:0] n
  );
    logic [3:0] r;
    logic [5:0] c;
    r = n[4:1];
    c = n[0] ? 6'd27 + {2'b00, r} : 6'd18;
    label_word = {OH + {7'd0, n[0]}, OV + {4'd0, r}, c};
  endfunction

  // Hex digit pos (0 = MSB) of val; top digit zero-padded.
  function automatic logic [21:0] digit_word(
    input logic [IW-1:0]         r,
    input logic [KW-1:0]         pos,
    input logic [DATA_WIDTH-1:0] val
  );
    logic [PW-1:0] pv;
    logic [3:0]    d;
    logic [5:0]    c;
    pv = PW'(val);
    d  = pv[4*(NDIG-1-int'(pos)) +: 4];
    unique case (1'b1)
      (d < 4'd10): c = 6'd27 + {2'b00, d};
      default:     c = {2'b00, d} - 6'd9;
    endcase
    digit_word = {OH + 8'd3 + 8'(pos), OV + 8'(r), c};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_LABEL;
      lbl_cnt   <= '0;
      idx       <= '0;
      k         <= '0;
      dirty     <= '0;
      term_w_en <= 1'b0;
      term_h    <= '0;
      term_v    <= '0;
      term_char <= '0;
      init_done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      unique case (state)
        S_LABEL: begin
          if (!term_w_en) begin
            term_w_en <= 1'b1;
            {term_h, term_v, term_char} <= label_word(lbl_cnt);
          end else if (term_w_ready) begin
            if (lbl_cnt == LBL_LAST) begin
              term_w_en <= 1'b0;
              dirty     <= '1;
              idx       <= '0;
              state     <= S_SCAN;
            end else begin
              lbl_cnt <= lbl_cnt + 1'b1;
              {term_h, term_v, term_char} <= label_word(lbl_cnt + 1'b1);
            end
          end
        end
        S_SCAN: begin
          if (dirty == '0) begin
            init_done <= 1'b1;
          end
          if (changed) begin
            // Digit 0 comes straight from cur, the value being latched.
            shadow[idx] <= cur;
            dirty[idx]  <= 1'b0;
            k           <= '0;
            term_w_en   <= 1'b1;
            state       <= S_WRITE;
            {term_h, term_v, term_char} <= digit_word(idx, '0, cur);
          end else begin
            idx <= idx_nxt;
          end
        end
        S_WRITE: begin
          if (xfer) begin
            if (k == K_LAST) begin
              term_w_en <= 1'b0;
              idx       <= idx_nxt;
              state     <= S_SCAN;
            end else begin
              k <= k + 1'b1;
              {term_h, term_v, term_char} <=
                digit_word(idx, k + 1'b1, shadow[idx]);
            end
          end
        end
        default: state <= S_LABEL;
      endcase
      // Later assignment overrides a same-cycle SCAN clear.
      if (force_refresh) begin
        dirty <= '1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_term_writer.sv
// tb_regfile_term_writer: directed bench for regfile_term_writer.
// Captures every transfer and compares against hand-built expectations.

module tb_regfile_term_writer;

  localparam int NR = 7;
  localparam int DW = 16;

  typedef struct {
    int          r;
    logic [15:0] val;
    logic [23:0] ch;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR*DW-1:0] regs;
  logic             force_refresh;
  logic [7:0]       term_h;
  logic [7:0]       term_v;
  logic [5:0]       term_char;
  logic             term_w_en;
  logic             term_w_ready = 1'b1;
  logic             init_done;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          bp_mode = 1'b0;
  logic [21:0] wq[$];
  int          wt[$];
  bit          stall_p = 1'b0;
  logic [21:0] hold_p;

  regfile_term_writer #(
    .NUM_REGS(NR),
    .DATA_WIDTH(DW),
    .ORIGIN_H(0),
    .ORIGIN_V(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .regs(regs),
    .force_refresh(force_refresh),
    .term_h(term_h),
    .term_v(term_v),
    .term_char(term_char),
    .term_w_en(term_w_en),
    .term_w_ready(term_w_ready),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    term_w_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Transfer happens on the next rising edge if en && ready here.
  always @(negedge clk) begin
    if (!rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p)
        chk("stall_hold", {term_w_en, term_h, term_v, term_char},
            {1'b1, hold_p});
      if (term_w_en && term_w_ready) begin
        wq.push_back({term_h, term_v, term_char});
        wt.push_back(cyc);
      end
      stall_p = term_w_en && !term_w_ready;
      hold_p  = {term_h, term_v, term_char};
    end
  end

  function automatic logic [5:0] hexc(input logic [3:0] d);
    return (d < 10) ? 6'(27 + d) : 6'(d - 9);
  endfunction

  task automatic set_reg(input int r, input logic [15:0] v);
    regs[r*DW +: DW] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_writes(input string nm, input int n, input int budget);
    int i;
    i = 0;
    while (wq.size() < n && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({nm, "_count"}, wq.size(), n);
  endtask

  task automatic wait_init(input string nm);
    int i;
    i = 0;
    while (!init_done && i < 20) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(nm, init_done, 1);
  endtask

  task automatic check_paint(input string nm);
    logic [21:0] e[$];
    for (int i = 0; i < NR; i++) begin
      e.push_back({8'd0, 8'(i), 6'd18});
      e.push_back({8'd1, 8'(i), 6'(27 + i)});
    end
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 4; k++)
        e.push_back({8'(3 + k), 8'(i), 6'(27 + i)});
    wait_writes(nm, e.size(), 400);
    idle(10);
    chk({nm, "_no_extra"}, wq.size(), e.size());
    for (int j = 0; j < e.size() && j < wq.size(); j++)
      chk($sformatf("%s_w%0d", nm, j), wq[j], e[j]);
  endtask

  task automatic paint_regs();
    for (int i = 0; i < NR; i++) set_reg(i, 16'(16'h1111 * i));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    logic [21:0] e[$];
    int          q;
    int          found;
    int          seen[NR][4];
    int          h, v, kk;

    tbl[0] = '{2, 16'hBEEF, {6'd2,  6'd5,  6'd5,  6'd6}};
    tbl[1] = '{0, 16'h0F0A, {6'd27, 6'd6,  6'd27, 6'd1}};
    tbl[2] = '{6, 16'hFFFF, {6'd6,  6'd6,  6'd6,  6'd6}};
    tbl[3] = '{1, 16'hA5C3, {6'd1,  6'd32, 6'd3,  6'd30}};
    tbl[4] = '{5, 16'h9087, {6'd36, 6'd27, 6'd35, 6'd34}};
    tbl[5] = '{2, 16'h0000, {6'd27, 6'd27, 6'd27, 6'd27}};

    force_refresh = 1'b0;
    paint_regs();
    rst = 1'b0;
    idle(3);
    chk("rst_en",   term_w_en, 0);
    chk("rst_h",    term_h, 0);
    chk("rst_v",    term_v, 0);
    chk("rst_char", term_char, 0);
    chk("rst_init", init_done, 0);

    @(negedge clk);
    wq.delete();
    wt.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_present", {term_w_en, term_h, term_v, term_char},
        {1'b1, 8'd0, 8'd0, 6'd18});
    check_paint("paint");
    if (wq.size() >= 42) begin
      chk("label_span", wt[13] - wt[0], 13);
      chk("dump_span", wt[41] - wt[13], 35);
    end
    wait_init("init_done");

    q = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (term_w_en) q++;
    end
    chk("quiet_en_cycles", q, 0);
    chk("init_sticky", init_done, 1);

    foreach (tbl[t]) begin
      wq.delete();
      set_reg(tbl[t].r, tbl[t].val);
      wait_writes($sformatf("tbl%0d", t), 4, 36);
      idle(40);
      chk($sformatf("tbl%0d_only4", t), wq.size(), 4);
      for (int k = 0; k < 4 && k < wq.size(); k++)
        chk($sformatf("tbl%0d_d%0d", t, k), wq[k],
            {8'(3 + k), 8'(tbl[t].r), tbl[t].ch[(3-k)*6 +: 6]});
    end

    wq.delete();
    set_reg(4, 16'h1234);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (term_w_en && term_w_ready && term_h == 8'd3 && term_v == 8'd4)
        found = 1;
    end
    chk("mid_first_seen", found, 1);
    @(posedge clk);
    #1;
    set_reg(4, 16'hABCD);
    wait_writes("mid", 8, 80);
    idle(40);
    chk("mid_only8", wq.size(), 8);
    e.delete();
    e.push_back({8'd3, 8'd4, 6'd28});
    e.push_back({8'd4, 8'd4, 6'd29});
    e.push_back({8'd5, 8'd4, 6'd30});
    e.push_back({8'd6, 8'd4, 6'd31});
    e.push_back({8'd3, 8'd4, 6'd1});
    e.push_back({8'd4, 8'd4, 6'd2});
    e.push_back({8'd5, 8'd4, 6'd3});
    e.push_back({8'd6, 8'd4, 6'd4});
    for (int j = 0; j < 8 && j < wq.size(); j++)
      chk($sformatf("mid_w%0d", j), wq[j], e[j]);

    wq.delete();
    force_refresh = 1'b1;
    @(posedge clk);
    #1;
    force_refresh = 1'b0;
    wait_writes("refresh", 28, 60);
    idle(40);
    chk("refresh_only28", wq.size(), 28);
    foreach (seen[a, b]) seen[a][b] = 0;
    foreach (wq[j]) begin
      h  = int'(wq[j][21:14]);
      v  = int'(wq[j][13:6]);
      kk = h - 3;
      if (v < NR && kk >= 0 && kk < 4) begin
        seen[v][kk]++;
        chk($sformatf("refresh_r%0d_d%0d", v, kk), wq[j][5:0],
            hexc(regs[v*DW + (3-kk)*4 +: 4]));
      end
    end
    foreach (seen[a, b])
      chk($sformatf("refresh_seen_r%0d_d%0d", a, b), seen[a][b], 1);

    force_refresh = 1'b1;
    @(posedge clk);
    #1;
    force_refresh = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (term_w_en && term_h == 8'd4) found = 1;
    end
    chk("mid_burst_seen", found, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_en",   term_w_en, 0);
    chk("arst_h",    term_h, 0);
    chk("arst_v",    term_v, 0);
    chk("arst_char", term_char, 0);
    chk("arst_init", init_done, 0);

    bp_mode = 1'b1;
    paint_regs();
    idle(2);
    @(negedge clk);
    wq.delete();
    wt.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_first_present", {term_w_en, term_h, term_v, term_char},
        {1'b1, 8'd0, 8'd0, 6'd18});
    check_paint("bp_paint");
    wait_init("bp_init_done");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
